// File: rtl/conv2d_mac_pipeline_if.sv
// Window / kernel-load / result bundle for the conv2d MAC pipeline.
// The slave modport is the MAC's view; the master modport is the driver's view.
interface conv2d_mac_pipeline_if #(
    parameter int filtDimension = 3,
    parameter int bitWidth      = 16
);
    logic [0:filtDimension-1][0:filtDimension-1][bitWidth-1:0] windowIn;
    logic                       inValid;
    logic                       inReady;
    logic signed [bitWidth-1:0] weightIn;
    logic                       weightLoad;
    logic                       weightsLoaded;
    logic signed [bitWidth-1:0] pixelOut;
    logic                       outValid;
    logic                       outReady;

    modport master (
        output windowIn, inValid, weightIn, weightLoad, outReady,
        input  inReady, weightsLoaded, pixelOut, outValid
    );

    modport slave (
        input  windowIn, inValid, weightIn, weightLoad, outReady,
        output inReady, weightsLoaded, pixelOut, outValid
    );
endinterface

// File: rtl/conv2d_mac_pipeline.sv
// 4-stage window x kernel MAC: products, row sums, total+bias+round, shift/saturate/ReLU.
// Kernel and bias are loaded serially; the whole pipe freezes while the output is stalled.
module conv2d_mac_pipeline #(
    parameter int filtDimension = 3,
    parameter int bitWidth      = 16,
    parameter int fracBits      = 8,
    parameter int accWidth      = 2*bitWidth+4,
    parameter bit doReLU        = 1'b1
) (
    input logic                  clock,
    input logic                  reset,
    conv2d_mac_pipeline_if.slave bus
);
    localparam int N  = filtDimension*filtDimension;
    localparam int PW = 2*bitWidth;
    localparam int IW = $clog2(N+1);

    localparam logic signed [accWidth-1:0] RND  = accWidth'(1) << (fracBits-1);
    localparam logic signed [accWidth-1:0] MAXV =
        $signed({{(accWidth-bitWidth+1){1'b0}}, {(bitWidth-1){1'b1}}});
    localparam logic signed [accWidth-1:0] MINV = ~MAXV;

    logic signed [bitWidth-1:0] r_kern [N];
    logic signed [bitWidth-1:0] r_bias;
    logic [IW-1:0]              r_loadIdx;
    logic                       r_loaded;

    logic signed [PW-1:0]       r_prod [N];
    logic signed [bitWidth-1:0] r_bias1;
    logic signed [accWidth-1:0] r_row [filtDimension];
    logic signed [accWidth-1:0] r_biasTerm;
    logic signed [accWidth-1:0] r_total;
    logic signed [bitWidth-1:0] r_pix;
    logic                       r_v1, r_v2, r_v3, r_v4;

    logic                       w_stall;
    logic                       w_accept;
    logic signed [bitWidth-1:0] w_pix [N];
    logic signed [accWidth-1:0] w_row [filtDimension];
    logic signed [accWidth-1:0] w_sum;
    logic signed [accWidth-1:0] w_shift;
    logic signed [bitWidth-1:0] w_res;

    assign w_stall           = r_v4 & ~bus.outReady;
    assign bus.inReady       = r_loaded & ~bus.weightLoad & ~w_stall;
    assign w_accept          = bus.inValid & bus.inReady;
    assign bus.weightsLoaded = r_loaded;
    assign bus.outValid      = r_v4;
    assign bus.pixelOut      = r_pix;

    // Any write below the bias slot invalidates the resident set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_loadIdx <= '0;
            r_loaded  <= 1'b0;
            r_bias    <= '0;
            for (int i = 0; i < N; i++) r_kern[i] <= '0;
        end else if (bus.weightLoad) begin
            if (r_loadIdx == IW'(N)) begin
                r_bias    <= bus.weightIn;
                r_loadIdx <= '0;
                r_loaded  <= 1'b1;
            end else begin
                r_kern[r_loadIdx] <= bus.weightIn;
                r_loadIdx         <= r_loadIdx + IW'(1);
                r_loaded          <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < filtDimension; r++) begin
            for (int c = 0; c < filtDimension; c++) begin
                w_pix[r*filtDimension+c] = bus.windowIn[r][c];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < filtDimension; r++) begin
            w_row[r] = '0;
            for (int c = 0; c < filtDimension; c++) begin
                w_row[r] = w_row[r] + accWidth'(r_prod[r*filtDimension+c]);
            end
        end
    end

    always_comb begin
        w_sum = r_biasTerm;
        for (int r = 0; r < filtDimension; r++) begin
            w_sum = w_sum + r_row[r];
        end
    end

    always_comb begin
        w_shift = r_total >>> fracBits;
        if (w_shift > MAXV) begin
            w_res = MAXV[bitWidth-1:0];
        end else if (w_shift < MINV) begin
            w_res = MINV[bitWidth-1:0];
        end else begin
            w_res = w_shift[bitWidth-1:0];
        end
        if (doReLU && w_shift[accWidth-1]) begin
            w_res = '0;
        end
    end

    // Bias travels with the products so a reload cannot touch in-flight windows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_v4       <= 1'b0;
            r_bias1    <= '0;
            r_biasTerm <= '0;
            r_total    <= '0;
            r_pix      <= '0;
            for (int i = 0; i < N; i++) r_prod[i] <= '0;
            for (int r = 0; r < filtDimension; r++) r_row[r] <= '0;
        end else if (!w_stall) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
            if (w_accept) begin
                for (int i = 0; i < N; i++) begin
                    r_prod[i] <= PW'(w_pix[i]) * PW'(r_kern[i]);
                end
                r_bias1 <= r_bias;
            end
            if (r_v1) begin
                for (int r = 0; r < filtDimension; r++) r_row[r] <= w_row[r];
                r_biasTerm <= (accWidth'(r_bias1) <<< fracBits) + RND;
            end
            if (r_v2) begin
                r_total <= w_sum;
            end
            if (r_v3) begin
                r_pix <= w_res;
            end
        end
    end
endmodule
